yuv422_to_rgb: RTL and testbench

YUV422_TO_RGB -- requirements
Module: yuv422_to_rgb

---
 rtl/yuv422_to_rgb_pkg.sv | 33 +++
 rtl/yuv422_to_rgb_pix.sv | 34 +++
 rtl/yuv422_to_rgb.sv | 104 ++++++++++
 tb/tb_yuv422_to_rgb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yuv422_to_rgb_pkg.sv
// Shared constants for the YUV422->RGB converter: BT.601 full-range coefficients,
// chroma offset, fixed-point shift, clamp bounds and the word-register state encoding.
package yuv422_to_rgb_pkg;

    localparam int PIX_W  = 8;
    localparam int CALC_W = 20;

    localparam logic signed [CALC_W-1:0] COEF_RV   = 20'sd359;
    localparam logic signed [CALC_W-1:0] COEF_GU   = 20'sd88;
    localparam logic signed [CALC_W-1:0] COEF_GV   = 20'sd183;
    localparam logic signed [CALC_W-1:0] COEF_BU   = 20'sd454;
    localparam logic signed [CALC_W-1:0] UV_OFFSET = 20'sd128;
    localparam logic signed [CALC_W-1:0] CLAMP_MIN = 20'sd0;
    localparam logic signed [CALC_W-1:0] CLAMP_MAX = 20'sd255;
    localparam int                       FRAC_SHIFT = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } word_state_t;

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [CALC_W-1:0] v);
        if (v < CLAMP_MIN) begin
            return '0;
        end else if (v > CLAMP_MAX) begin
            return '1;
        end else begin
            return v[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/yuv422_to_rgb_pix.sv
// Combinational conversion of one (Y,U,V) triple to a saturated (R,G,B) triple.
// Zero latency; no flow control of its own.
module yuv2rgb_pix
    import yuv422_to_rgb_pkg::*;
(
    input  logic [PIX_W-1:0] y,
    input  logic [PIX_W-1:0] u,
    input  logic [PIX_W-1:0] v,
    output logic [PIX_W-1:0] r,
    output logic [PIX_W-1:0] g,
    output logic [PIX_W-1:0] b
);

    logic signed [CALC_W-1:0] y_s;
    logic signed [CALC_W-1:0] d_u;
    logic signed [CALC_W-1:0] d_v;
    logic signed [CALC_W-1:0] r_s;
    logic signed [CALC_W-1:0] g_s;
    logic signed [CALC_W-1:0] b_s;

    // Arithmetic shift floors negative chroma terms rather than truncating toward zero.
    always_comb begin
        y_s = $signed({{(CALC_W-PIX_W){1'b0}}, y});
        d_u = $signed({{(CALC_W-PIX_W){1'b0}}, u}) - UV_OFFSET;
        d_v = $signed({{(CALC_W-PIX_W){1'b0}}, v}) - UV_OFFSET;
        r_s = y_s + ((COEF_RV * d_v) >>> FRAC_SHIFT);
        g_s = y_s - ((COEF_GU * d_u + COEF_GV * d_v) >>> FRAC_SHIFT);
        b_s = y_s + ((COEF_BU * d_u) >>> FRAC_SHIFT);
        r   = clamp_pix(r_s);
        g   = clamp_pix(g_s);
        b   = clamp_pix(b_s);
    end

endmodule

// File: rtl/yuv422_to_rgb.sv
// Unpacks each YUV422 word into two RGB pixels; pixel0 one cycle after accept, pixel1 the next.
// Valid/ready both sides; output register holds under OUT_READY=0 and input stalls until pixel1 issues.
module yuv422_to_rgb
    import yuv422_to_rgb_pkg::*;
#(
    parameter int DATA_WIDTH_YUV = 32,
    parameter int DATA_WIDTH_RGB = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [DATA_WIDTH_YUV-1:0] IN_DATA,
    input  logic                      IN_VALID,
    input  logic                      IN_LAST,
    output logic                      IN_READY,
    output logic [DATA_WIDTH_RGB-1:0] OUT_R,
    output logic [DATA_WIDTH_RGB-1:0] OUT_G,
    output logic [DATA_WIDTH_RGB-1:0] OUT_B,
    output logic                      OUT_VALID,
    output logic                      OUT_LAST,
    input  logic                      OUT_READY
);

    word_state_t               state_q;
    word_state_t               state_d;
    logic [DATA_WIDTH_YUV-1:0] word_q;
    logic                      last_q;
    logic                      load;
    logic                      accept;
    logic [PIX_W-1:0]          y_sel;
    logic [PIX_W-1:0]          pix_r;
    logic [PIX_W-1:0]          pix_g;
    logic [PIX_W-1:0]          pix_b;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A new word may enter in the same cycle pixel1 leaves, which keeps the pipe bubble-free.
    always_comb begin
        state_d  = state_q;
        IN_READY = 1'b0;
        load     = (state_q != EMPTY) && (!OUT_VALID || OUT_READY);
        case (state_q)
            EMPTY: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_d = HOLD0;
            end
            HOLD0: begin
                if (load) state_d = HOLD1;
            end
            HOLD1: begin
                IN_READY = load;
                if (load) state_d = IN_VALID ? HOLD0 : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign accept = IN_VALID && IN_READY;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            word_q <= '0;
            last_q <= 1'b0;
        end else if (accept) begin
            word_q <= IN_DATA;
            last_q <= IN_LAST;
        end
    end

    assign y_sel = (state_q == HOLD1) ? word_q[15:8] : word_q[31:24];

    yuv2rgb_pix u_pix (
        .y (y_sel),
        .u (word_q[23:16]),
        .v (word_q[7:0]),
        .r (pix_r),
        .g (pix_g),
        .b (pix_b)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            OUT_VALID <= 1'b0;
            OUT_LAST  <= 1'b0;
            OUT_R     <= '0;
            OUT_G     <= '0;
            OUT_B     <= '0;
        end else if (load) begin
            OUT_VALID <= 1'b1;
            OUT_LAST  <= (state_q == HOLD1) && last_q;
            OUT_R     <= pix_r;
            OUT_G     <= pix_g;
            OUT_B     <= pix_b;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// Bench for yuv422_to_rgb: directed vector table, latency/throughput/reset sequences,
// and randomized back-to-back traffic scored against an integer-arithmetic reference.
module tb_yuv422_to_rgb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_LAST;
    logic        IN_READY;
    logic [7:0]  OUT_R;
    logic [7:0]  OUT_G;
    logic [7:0]  OUT_B;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic        OUT_READY;

    always #5 CLK = ~CLK;

    yuv422_to_rgb #(.DATA_WIDTH_YUV(32), .DATA_WIDTH_RGB(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_LAST   (IN_LAST),
        .IN_READY  (IN_READY),
        .OUT_R     (OUT_R),
        .OUT_G     (OUT_G),
        .OUT_B     (OUT_B),
        .OUT_VALID (OUT_VALID),
        .OUT_LAST  (OUT_LAST),
        .OUT_READY (OUT_READY)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: pixel = {last, r, g, b}
    function automatic int floor_div256(input int a);
        if (a >= 0) return a / 256;
        return -((-a + 255) / 256);
    endfunction

    function automatic int sat(input int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    function automatic logic [24:0] ref_pix(input logic [7:0] y, input logic [7:0] u,
                                            input logic [7:0] v, input logic last);
        int yy, du, dv, r, g, b;
        yy = int'(y);
        du = int'(u) - 128;
        dv = int'(v) - 128;
        r  = sat(yy + floor_div256(359 * dv));
        g  = sat(yy - floor_div256(88 * du + 183 * dv));
        b  = sat(yy + floor_div256(454 * du));
        return {last, 8'(r), 8'(g), 8'(b)};
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle
    logic [24:0] exp_q[$];
    logic [24:0] got_q[$];
    int          xt_q[$];
    int          owed = 0;
    int          xfers = 0;
    int          cyc_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [24:0] prev_pix;
    logic [24:0] cur_pix;
    logic        exp_rdy;
    int          fsm_pend;

    always @(negedge CLK) begin
        cyc_cnt++;
        if (!RESET) begin
            exp_q.delete();
            owed       = 0;
            stall_prev = 1'b0;
        end else begin
            cur_pix = {OUT_LAST, OUT_R, OUT_G, OUT_B};
            if (stall_prev) check("hold_stable", cur_pix, prev_pix);
            fsm_pend = owed - int'(OUT_VALID);
            exp_rdy  = (fsm_pend == 0) || (fsm_pend == 1 && (!OUT_VALID || OUT_READY));
            check("in_ready", IN_READY, exp_rdy);
            if (OUT_VALID && OUT_READY) begin
                xfers++;
                got_q.push_back(cur_pix);
                xt_q.push_back(cyc_cnt);
                if (exp_q.size() == 0) check("spurious_pixel", 1, 0);
                else check("pixel", cur_pix, exp_q.pop_front());
                owed--;
            end
            if (IN_VALID && IN_READY) begin
                exp_q.push_back(ref_pix(IN_DATA[31:24], IN_DATA[23:16], IN_DATA[7:0], 1'b0));
                exp_q.push_back(ref_pix(IN_DATA[15:8], IN_DATA[23:16], IN_DATA[7:0], IN_LAST));
                owed += 2;
            end
            stall_prev = OUT_VALID && !OUT_READY;
            prev_pix   = cur_pix;
        end
    end

    logic rand_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_rdy) OUT_READY = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (IN_READY) begin
                ok = 1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        IN_DATA  = d;
        IN_LAST  = l;
        IN_VALID = 1'b1;
        wait_accept();
        IN_VALID = 1'b0;
        IN_DATA  = $urandom;
        IN_LAST  = 1'($urandom_range(0, 1));
    endtask

    task automatic stream(input int n);
        IN_VALID = 1'b1;
        for (int k = 0; k < n; k++) begin
            IN_DATA = $urandom;
            IN_LAST = 1'($urandom_range(0, 1));
            wait_accept();
        end
        IN_VALID = 1'b0;
        IN_DATA  = $urandom;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (owed == 0) break;
        end
        check("drain", owed, 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (got_q.size() >= n) break;
        end
        check("got_count", got_q.size(), n);
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [24:0] p0;
        logic [24:0] p1;
    } vec_t;

    vec_t tbl[5];
    int   x0;

    initial begin
        tbl[0] = '{32'h80808080, 1'b1, {1'b0, 24'h808080}, {1'b1, 24'h808080}};
        tbl[1] = '{32'h008000FF, 1'b0, {1'b0, 24'hB20000}, {1'b0, 24'hB20000}};
        tbl[2] = '{32'hFFFFFFFF, 1'b1, {1'b0, 24'hFF79FF}, {1'b1, 24'hFF79FF}};
        tbl[3] = '{32'hFF00FF80, 1'b1, {1'b0, 24'hFFFF1C}, {1'b1, 24'hFFFF1C}};
        tbl[4] = '{32'h40C02060, 1'b1, {1'b0, 24'h1341B1}, {1'b1, 24'h002191}};

        RESET = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; IN_LAST = 1'b0; OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_last", OUT_LAST, 0);
        check("rst_rgb", {OUT_R, OUT_G, OUT_B}, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("ready_after_reset", IN_READY, 1);

        // Latency: grey word, pixel0 after E+1, pixel1 after E+2
        OUT_READY = 1'b1;
        IN_DATA = 32'h80808080; IN_LAST = 1'b1; IN_VALID = 1'b1;
        @(negedge CLK);
        check("lat_ready", IN_READY, 1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0; IN_DATA = $urandom;
        check("lat_e0_valid", OUT_VALID, 0);
        @(posedge CLK);
        #1;
        check("lat_e1_valid", OUT_VALID, 1);
        check("lat_e1_pix", {OUT_LAST, OUT_R, OUT_G, OUT_B}, {1'b0, 24'h808080});
        @(posedge CLK);
        #1;
        check("lat_e2_valid", OUT_VALID, 1);
        check("lat_e2_pix", {OUT_LAST, OUT_R, OUT_G, OUT_B}, {1'b1, 24'h808080});
        @(posedge CLK);
        #1;
        check("lat_e3_valid", OUT_VALID, 0);
        wait_drain();

        for (int i = 0; i < 5; i++) begin
            got_q.delete();
            send(tbl[i].d, tbl[i].l);
            wait_got(2);
            if (got_q.size() >= 2) begin
                check($sformatf("vec%0d_p0", i), got_q[0], tbl[i].p0);
                check($sformatf("vec%0d_p1", i), got_q[1], tbl[i].p1);
            end
        end

        // Throughput: 4 words back-to-back, 8 pixels on consecutive cycles
        xt_q.delete();
        stream(4);
        wait_drain();
        check("tput_count", xt_q.size(), 8);
        if (xt_q.size() == 8) check("tput_span", xt_q[7] - xt_q[0], 7);

        // Randomized back-to-back traffic with random downstream stalls
        for (int round = 0; round < 3; round++) begin
            x0 = xfers;
            rand_rdy = 1'b1;
            stream(8);
            wait_drain();
            rand_rdy = 1'b0;
            check("rand_pixel_count", xfers - x0, 16);
        end
        @(posedge CLK);
        #2;

        // Reset while pixel1 pending and output stalled
        OUT_READY = 1'b0;
        send(32'h40C02060, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        check("pre_rst_valid", OUT_VALID, 1);
        RESET = 1'b0;
        #1;
        check("mid_rst_valid", OUT_VALID, 0);
        check("mid_rst_rgb", {OUT_LAST, OUT_R, OUT_G, OUT_B}, 0);
        repeat (2) @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        RESET = 1'b1;
        x0 = xfers;
        @(posedge CLK);
        #1;
        check("post_rst_ready", IN_READY, 1);
        repeat (5) @(posedge CLK);
        #1;
        check("no_stale_pixel", xfers - x0, 0);
        got_q.delete();
        send(32'hFF00FF80, 1'b0);
        wait_got(2);
        if (got_q.size() >= 2) begin
            check("post_rst_p0", got_q[0], {1'b0, 24'hFFFF1C});
            check("post_rst_p1", got_q[1], {1'b0, 24'hFFFF1C});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
